// File: rtl/mul_mant_seq.sv
// Sequential radix-2 shift-add significand multiplier: WIDTH steps per product,
// with the normalized fraction and the exponent-adjust carry alongside the full product.
module mul_mant_seq #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     sig1,
    input  logic [WIDTH-1:0]     sig2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 carry,
    output logic [WIDTH-2:0]     mant_out
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mplr_nxt;
    logic [PW-1:0]      product_nxt;
    logic [WIDTH-2:0]   mant_nxt;
    logic               last_step;

    // One shift-add step; the adder carry-out becomes the new accumulator MSB.
    always_comb begin
        sum         = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        acc_nxt     = sum[WIDTH:1];
        mplr_nxt    = {sum[0], mplr_q[WIDTH-1:1]};
        product_nxt = {acc_nxt, mplr_nxt};
        mant_nxt    = product_nxt[PW-1] ? product_nxt[PW-2:WIDTH]
                                        : product_nxt[PW-3:WIDTH-1];
        last_step   = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; results load only on the final step.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            carry    <= 1'b0;
            mant_out <= '0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q <= sig1;
                        mplr_q  <= sig2;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    acc_q  <= acc_nxt;
                    mplr_q <= mplr_nxt;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        product  <= product_nxt;
                        carry    <= product_nxt[PW-1];
                        mant_out <= mant_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_mant_seq.sv
// Scoreboard bench for mul_mant_seq (WIDTH=24): directed operands with
// hand-computed products, done-cycle timing, ignored starts and mid-op reset.
module tb_mul_mant_seq;

    localparam int unsigned W = 24;

    logic            CLK = 1'b0;
    logic            RST;
    logic            start;
    logic [W-1:0]    sig1;
    logic [W-1:0]    sig2;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;
    logic            carry;
    logic [W-2:0]    mant_out;

    typedef struct {
        logic [2*W-1:0] p;
        logic           c;
        logic [W-2:0]   m;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mul_mant_seq #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .sig1     (sig1),
        .sig2     (sig2),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .carry    (carry),
        .mant_out (mant_out)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(cyc), 64'(-1));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("product", 64'(product), 64'(e.p));
                check("carry", 64'(carry), 64'(e.c));
                check("mant_out", 64'(mant_out), 64'(e.m));
            end
        end
    end

    // Called at a negedge: start is sampled on the next posedge (cyc+1),
    // and done is visible at the negedge W edges later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] p, input logic c, input logic [W-2:0] m);
        sig1  = a;
        sig2  = b;
        start = 1'b1;
        sb.push_back('{p: p, c: c, m: m, cyc: cyc + 1 + W});
        @(negedge CLK);
        start = 1'b0;
        sig1  = W'($urandom);
        sig2  = W'($urandom);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check(name, 64'(sb.size()), 64'd0);
        repeat (3) @(negedge CLK);
    endtask

    logic [W-1:0]   ha [3] = '{24'h800000, 24'hFFFFFF, 24'hC00000};
    logic [W-1:0]   hb [3] = '{24'hC00000, 24'h800000, 24'hFFFFFF};
    logic [2*W-1:0] hp [3] = '{48'h600000000000, 48'h7FFFFF800000, 48'hBFFFFF400000};
    logic           hc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-2:0]   hm [3] = '{23'h400000, 23'h7FFFFF, 23'h3FFFFF};

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        sig1  = '0;
        sig2  = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_mant", 64'(mant_out), 64'd0);
        RST = 1'b0;

        // 1.0 x 1.0, issued in the first cycle out of reset
        issue(24'h800000, 24'h800000, 48'h400000000000, 1'b0, 23'h000000);
        check("busy_run", 64'(busy), 64'd1);
        drain("drain_one");
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_hold_product", 64'(product), 64'h400000000000);

        issue(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 23'h7FFFFE);
        drain("drain_max");
        issue(24'h000000, 24'hABCDEF, 48'h000000000000, 1'b0, 23'h000000);
        drain("drain_zero");
        issue(24'h800001, 24'h800001, 48'h400001000001, 1'b0, 23'h000002);
        drain("drain_odd");

        // start during RUN is ignored; operand changes during RUN have no effect
        issue(24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, 23'h100000);
        repeat (3) @(negedge CLK);
        sig1  = 24'hFFFFFF;
        sig2  = 24'h123456;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        drain("drain_ignored");
        repeat (40) @(negedge CLK);

        // start held high: three back-to-back operations W+2 cycles apart
        for (int i = 0; i < 3; i++) begin
            sig1  = ha[i];
            sig2  = hb[i];
            start = 1'b1;
            sb.push_back('{p: hp[i], c: hc[i], m: hm[i], cyc: cyc + 1 + W});
            if (i < 2) repeat (W + 2) @(negedge CLK);
            else @(negedge CLK);
        end
        start = 1'b0;
        drain("drain_held");
        repeat (30) @(negedge CLK);

        // reset mid-operation aborts; next start right after reset completes
        issue(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 23'h7FFFFE);
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        sb.delete();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        check("abort_carry", 64'(carry), 64'd0);
        check("abort_mant", 64'(mant_out), 64'd0);
        RST = 1'b0;
        issue(24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, 23'h100000);
        drain("drain_after_abort");
        repeat (30) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
